// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM port controller and the MEM stage.
package mem_ctrl_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam int unsigned RegBus       = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [RegBus-1:0] addr;
        logic [1:0]        size;
        logic [RegBus-1:0] wdata;
    } mem_req_t;

    // Byte count for an access; the unused encoding behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: return 3'd1;
            MEM_SIZE_H: return 3'd2;
            MEM_SIZE_W: return 3'd4;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and the MEM stage,
// sequencing 1/2/4-byte little-endian accesses as consecutive byte cycles.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [RAM_AW-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i,
    output logic              busy_o
);

    mem_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              is_if_q, is_if_d;
    logic [2:0]        step_q, step_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;

    logic              done_hi;
    logic              grant_mem;
    logic              grant_if;
    logic              if_abort;
    logic [2:0]        n_bytes;
    logic [31:0]       addr_k;
    logic [1:0]        rd_lane;

    // step_q = j means the coming edge is E(j) of the current access
    assign done_hi   = if_done_q | mem_done_q;
    assign grant_mem = ~done_hi & mem_req_i;
    assign grant_if  = ~done_hi & ~mem_req_i & if_req_i & ~if_flush_i;
    assign if_abort  = is_if_q & if_flush_i;
    assign n_bytes   = size_bytes(req_q.size);
    assign addr_k    = req_q.addr + 32'(step_q);
    assign rd_lane   = 2'(step_q - 3'd2);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d = mem_we_i ? ST_WRITE : ST_READ;
                end else if (grant_if) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (if_abort || step_q == 3'(n_bytes + 3'd1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (step_q == n_bytes) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the latched request, byte sequencing and registered outputs
    always_comb begin
        req_d       = req_q;
        is_if_d     = is_if_q;
        step_d      = step_q;
        rbuf_d      = rbuf_q;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = WriteDisable;
        case (state_q)
            ST_IDLE: begin
                step_d = 3'd1;
                rbuf_d = ZeroWord;
                if (grant_mem) begin
                    req_d   = '{addr: mem_addr_i, size: mem_size_i, wdata: mem_wdata_i};
                    is_if_d = 1'b0;
                    ram_a_d = RAM_AW'(mem_addr_i);
                    if (mem_we_i) begin
                        ram_wr_d   = WriteEnable;
                        ram_dout_d = mem_wdata_i[7:0];
                    end
                end else if (grant_if) begin
                    req_d   = '{addr: if_addr_i, size: MEM_SIZE_W, wdata: ZeroWord};
                    is_if_d = 1'b1;
                    ram_a_d = RAM_AW'(if_addr_i);
                end
            end
            ST_READ: begin
                if (!if_abort) begin
                    step_d = step_q + 3'd1;
                    if (step_q >= 3'd2) begin
                        rbuf_d[{rd_lane, 3'b000} +: 8] = ram_din_i;
                    end
                    if (step_q < n_bytes) begin
                        ram_a_d = RAM_AW'(addr_k);
                    end
                    if (step_q == 3'(n_bytes + 3'd1)) begin
                        if (is_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_d;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = rbuf_d;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (step_q < n_bytes) begin
                    step_d     = step_q + 3'd1;
                    ram_wr_d   = WriteEnable;
                    ram_a_d    = RAM_AW'(addr_k);
                    ram_dout_d = req_q.wdata[{step_q[1:0], 3'b000} +: 8];
                end else begin
                    mem_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            req_q       <= '0;
            is_if_q     <= 1'b0;
            step_q      <= 3'd0;
            rbuf_q      <= ZeroWord;
            if_done_q   <= 1'b0;
            if_data_q   <= ZeroWord;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= ZeroWord;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= WriteDisable;
        end else if (rdy) begin
            req_q       <= req_d;
            is_if_q     <= is_if_d;
            step_q      <= step_d;
            rbuf_q      <= rbuf_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
        end
    end

    assign if_done_o   = if_done_q;
    assign if_data_o   = if_data_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign ram_a_o     = ram_a_q;
    assign ram_dout_o  = ram_dout_q;
    assign ram_wr_o    = ram_wr_q & rdy;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
